// File: rtl/edgedet_pkg.sv
// Shared types and sizing helpers for the edge-detector frame controller.
package edgedet_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE,
      S_ERR
   } state_t;

   localparam int unsigned IMG_WIDTH_DEF  = 720;
   localparam int unsigned IMG_HEIGHT_DEF = 576;

   function automatic int unsigned cnt_w(input int unsigned w, input int unsigned h);
      return $clog2(w * h + 1);
   endfunction

endpackage

// File: rtl/beat_counter.sv
// Saturating beat counter with synchronous clear and a limit flag.
module beat_counter #(
   parameter int unsigned W     = 4,
   parameter int unsigned LIMIT = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         lim_o
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;

   assign cnt_o = cnt_q;
   assign lim_o = (cnt_q == LIM);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !lim_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/edgedet_frame_ctrl.sv
// Frame sequencer gating the filter's FIFO handshakes to exactly one image.
// Optional stall watchdog enabled by defining FRAME_WDT_EN.
module edgedet_frame_ctrl
   import edgedet_pkg::*;
#(
   parameter  int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter  int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter  int unsigned WDT_CYCLES = 4096,
   localparam int unsigned CNT_W      = cnt_w(IMG_WIDTH, IMG_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_empty,
   input  logic             f_in_rd_en,
   output logic             f_in_empty,
   input  logic             out_full,
   input  logic             f_out_wr_en,
   output logic             f_out_full,
   output logic             f_rst,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] in_cnt,
   output logic [CNT_W-1:0] out_cnt,
   output logic [15:0]      frame_cnt
);

   localparam int unsigned N = IMG_WIDTH * IMG_HEIGHT;

   state_t      state_q, state_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        active, in_beat, out_beat, in_lim, out_lim, cnt_clr, wdt_trip;

   assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

   // Limit flags close the gates combinationally so no beat past N can slip through.
   assign f_in_empty = active ? (in_empty | in_lim) : 1'b1;
   assign f_out_full = active ? (out_full | out_lim) : 1'b1;
   assign in_beat    = f_in_rd_en  & ~f_in_empty;
   assign out_beat   = f_out_wr_en & ~f_out_full;
   assign cnt_clr    = start & ((state_q == S_IDLE) || (state_q == S_ERR));

   assign busy      = active;
   assign done      = (state_q == S_DONE);
   assign f_rst     = ~active;
   assign frame_cnt = frame_cnt_q;

`ifdef FRAME_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] wdt_q, wdt_d;

   always_comb begin
      wdt_d = '0;
      if (active && !out_beat) begin
         wdt_d = wdt_q + 1'b1;
      end
   end

   assign wdt_trip = active && !out_beat && (wdt_q == WDT_W'(WDT_CYCLES - 1));
   assign err      = (state_q == S_ERR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`else
   assign wdt_trip = 1'b0;
   assign err      = 1'b0;
`endif

   beat_counter #(.W(CNT_W), .LIMIT(N)) u_in_cnt (
      .clk   (clk),
      .rst_n (rst),
      .clr_i (cnt_clr),
      .en_i  (in_beat),
      .cnt_o (in_cnt),
      .lim_o (in_lim)
   );

   beat_counter #(.W(CNT_W), .LIMIT(N)) u_out_cnt (
      .clk   (clk),
      .rst_n (rst),
      .clr_i (cnt_clr),
      .en_i  (out_beat),
      .cnt_o (out_cnt),
      .lim_o (out_lim)
   );

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         S_IDLE, S_ERR: if (start) state_d = S_RUN;
         S_RUN: begin
            if (out_lim)       state_d = S_DONE;
            else if (wdt_trip) state_d = S_ERR;
            else if (in_lim)   state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_lim)       state_d = S_DONE;
            else if (wdt_trip) state_d = S_ERR;
         end
         S_DONE: begin
            state_d     = S_IDLE;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_edgedet_frame_ctrl.sv
// Randomized bench for edgedet_frame_ctrl against a phase/count reference model.
module tb_edgedet_frame_ctrl;

   localparam int unsigned W   = 4;
   localparam int unsigned H   = 3;
   localparam int          N   = 12;
   localparam int          WDT = 16;
   localparam int unsigned CW  = $clog2(W * H + 1);

   typedef enum {P_IDLE, P_RUN, P_DRAIN, P_DONE, P_ERR} phase_t;

   logic          clk = 1'b0;
   logic          rst, start, in_empty, f_in_rd_en, f_in_empty;
   logic          out_full, f_out_wr_en, f_out_full, f_rst, busy, done, err;
   logic [CW-1:0] in_cnt, out_cnt;
   logic [15:0]   frame_cnt;

   always #5 clk = ~clk;

   edgedet_frame_ctrl #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .WDT_CYCLES (WDT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_empty    (in_empty),
      .f_in_rd_en  (f_in_rd_en),
      .f_in_empty  (f_in_empty),
      .out_full    (out_full),
      .f_out_wr_en (f_out_wr_en),
      .f_out_full  (f_out_full),
      .f_rst       (f_rst),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .in_cnt      (in_cnt),
      .out_cnt     (out_cnt),
      .frame_cnt   (frame_cnt)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   string       test_name = "reset";

   phase_t ph;
   int     m_in, m_out, m_frames, m_wdt, m_pend;
   int     cyc = 0, in_seen = 0, done_seen = 0, last_done = -1, gap = -1;
   bit     prev_busy = 1'b0;

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL [%s] %s: got %0d expected %0d", test_name, tag, got, exp);
      end
   endtask

   task automatic model_reset();
      ph = P_IDLE; m_in = 0; m_out = 0; m_frames = 0; m_wdt = 0; m_pend = 0;
   endtask

   // Percent probabilities for start, in_empty, out_full, read attempt, write attempt.
   task automatic drive(input int p_st, input int p_ie, input int p_of, input int p_rd, input int p_wr);
      start       = ($urandom_range(0, 99) < p_st);
      in_empty    = ($urandom_range(0, 99) < p_ie);
      out_full    = ($urandom_range(0, 99) < p_of);
      f_in_rd_en  = ($urandom_range(0, 99) < p_rd);
      f_out_wr_en = (m_pend > 0) && ($urandom_range(0, 99) < p_wr);
   endtask

   task automatic step();
      bit act, e_fie, e_fof, ib, ob, wdt_exp;
      int pre_in, pre_out;
      @(negedge clk);
      cyc++;
      act   = (ph == P_RUN) || (ph == P_DRAIN);
      e_fie = !act || in_empty || (m_in == N);
      e_fof = !act || out_full || (m_out == N);
      check("f_in_empty", f_in_empty, e_fie);
      check("f_out_full", f_out_full, e_fof);
      check("busy", busy, act);
      check("done", done, ph == P_DONE);
      check("err", err, ph == P_ERR);
      check("f_rst", f_rst, !act);
      check("in_cnt", in_cnt, m_in);
      check("out_cnt", out_cnt, m_out);
      check("frame_cnt", frame_cnt, m_frames);
      ib = f_in_rd_en && !e_fie;
      ob = f_out_wr_en && !e_fof;
      if (f_in_rd_en && !f_in_empty) in_seen++;
      if (done) begin
         done_seen++;
         last_done = cyc;
      end
      if (busy && !prev_busy && last_done >= 0 && gap < 0) gap = cyc - last_done;
      prev_busy = busy;
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         case (ph)
            P_IDLE, P_ERR: if (start) begin
               ph = P_RUN; m_in = 0; m_out = 0; m_wdt = 0; m_pend = 0;
            end
            P_RUN, P_DRAIN: begin
               pre_in  = m_in;
               pre_out = m_out;
               m_in   += int'(ib);
               m_out  += int'(ob);
               m_pend += int'(ib) - int'(ob);
               wdt_exp = 1'b0;
`ifdef FRAME_WDT_EN
               if (ob) m_wdt = 0;
               else begin
                  m_wdt++;
                  wdt_exp = (m_wdt == WDT);
               end
`endif
               if (pre_out == N) ph = P_DONE;
               else if (wdt_exp) begin
                  ph = P_ERR;
                  m_wdt = 0;
               end else if (pre_in == N) ph = P_DRAIN;
            end
            P_DONE: begin
               m_frames = (m_frames + 1) % 65536;
               ph = P_IDLE;
            end
            default: ph = P_IDLE;
         endcase
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0);
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; in_empty = 1'b1; out_full = 1'b1;
      f_in_rd_en = 1'b0; f_out_wr_en = 1'b0;
      model_reset();
      #1;
      do_reset();
      step();

      // Single frame, FIFOs always ready, filter keeps trying to read past N.
      test_name = "frame";
      in_seen = 0; done_seen = 0;
      drive(100, 0, 0, 100, 100);
      step();
      repeat (40) begin
         drive(0, 0, 0, 100, 100);
         step();
      end
      check("frame_in_beats", in_seen, 12);
      check("frame_done_pulses", done_seen, 1);
      check("frame_cnt_end", frame_cnt, 1);
      check("frame_in_cnt_hold", in_cnt, 12);
      check("overdrive_gate", f_in_empty, 1);

      // Random backpressure on both FIFOs.
      test_name = "backpressure";
      done_seen = 0;
      drive(100, 30, 50, 75, 75);
      step();
      repeat (250) begin
         drive(0, 30, 50, 75, 75);
         step();
      end
`ifndef FRAME_WDT_EN
      check("bp_done_pulses", done_seen, 1);
      check("bp_out_cnt", out_cnt, 12);
`endif

      // Free-running random traffic with stray starts.
      test_name = "random";
      repeat (600) begin
         drive(15, 25, 25, 70, 80);
         step();
      end

      // Reset in the middle of a frame.
      test_name = "reset_mid";
      do_reset();
      drive(100, 0, 0, 100, 100);
      step();
      repeat (5) begin
         drive(0, 0, 0, 100, 100);
         step();
      end
      done_seen = 0;
      rst = 1'b0;
      model_reset();
      step();
      check("rst_mid_busy", busy, 0);
      check("rst_mid_f_rst", f_rst, 1);
      check("rst_mid_in_cnt", in_cnt, 0);
      check("rst_mid_done_seen", done_seen, 0);
      rst = 1'b1;

      // Start held high: frames run back to back.
      test_name = "back2back";
      do_reset();
      last_done = -1; gap = -1;
      for (int i = 0; i < 120 && m_frames < 3; i++) begin
         drive(100, 0, 0, 100, 100);
         step();
      end
      check("b2b_frames", frame_cnt, 3);
      check("b2b_gap", gap, 2);

`ifdef FRAME_WDT_EN
      // Output stalled permanently: watchdog must trip.
      test_name = "watchdog";
      do_reset();
      drive(100, 0, 100, 100, 100);
      out_full = 1'b1;
      step();
      repeat (20) begin
         drive(0, 0, 100, 100, 100);
         step();
      end
      check("wdt_err", err, 1);
      check("wdt_f_rst", f_rst, 1);
      drive(100, 0, 0, 100, 100);
      step();
      drive(0, 0, 0, 100, 100);
      step();
      check("wdt_restart_busy", busy, 1);
      check("wdt_restart_err", err, 0);
`endif

      test_name = "idle";
      start = 1'b0;
      repeat (40) begin
         drive(0, 0, 0, 100, 100);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
